// File: rtl/mic_dma_pkg.sv
// mic_dma_pkg: shared types and constants for the microphone-array DMA writer.
//   mic_dma_state_t  - controller states (IDLE, WAIT_FRAME, WRITE, DONE)
//   NUM_MICS_DEFAULT - default number of mic words per frame
//   BURST_ONE        - Avalon burst count used for every write (single beat)
//   BYTEEN_ALL       - Avalon byte enable used for every write (all lanes)
package mic_dma_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FRAME,
        WRITE,
        DONE
    } mic_dma_state_t;

    localparam int unsigned NUM_MICS_DEFAULT = 4;
    localparam logic [2:0]  BURST_ONE        = 3'd1;
    localparam logic [3:0]  BYTEEN_ALL       = 4'hF;

endpackage

// File: rtl/mic_dma_writer.sv
// mic_dma_writer: Avalon-MM write-master that stores microphone-array frames.
// Each read_ready pulse writes one frame: select walks 1..NUM_MICS and the
// selected mic_data word is written to consecutive word addresses. After
// number_samples frames the block raises FINISHED until start is dropped.
//
// Ports:
//   CLK, RESET          - clock, asynchronous active-high reset
//   AM_ADDR             - byte address of the current write
//   AM_BURSTCOUNT       - always 1
//   AM_WRITE            - write request (held while AM_WAITREQUEST=1)
//   AM_WRITEDATA        - write data, passed straight from mic_data
//   AM_BYTEENABLE       - always all lanes
//   AM_WAITREQUEST      - slave stall
//   mic_data            - word of the mic currently on select (external mux)
//   select              - current mic index 1..NUM_MICS, 0 when not writing
//   start               - level enable; a 0->1 edge begins a transfer
//   read_ready          - one-cycle pulse: new frame available
//   start_address       - base byte address, sampled on start rise
//   number_samples      - frame count, sampled on start rise
//   FINISHED            - transfer complete, held while start stays high
//
// Build option: MIC_DMA_PENDING_FRAME_EN
//   Defined   - a read_ready arriving during WRITE is remembered (one deep)
//               and the next frame starts right after the current one.
//   Undefined - read_ready outside WAIT_FRAME is ignored.
module mic_dma_writer
    import mic_dma_pkg::*;
#(
    parameter int unsigned NUM_MICS = NUM_MICS_DEFAULT,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    output logic [ADDR_W-1:0] AM_ADDR,
    output logic [2:0]        AM_BURSTCOUNT,
    output logic              AM_WRITE,
    output logic [DATA_W-1:0] AM_WRITEDATA,
    output logic [3:0]        AM_BYTEENABLE,
    input  logic              AM_WAITREQUEST,
    input  logic [DATA_W-1:0] mic_data,
    output logic [2:0]        select,
    input  logic              start,
    input  logic              read_ready,
    input  logic [ADDR_W-1:0] start_address,
    input  logic [31:0]       number_samples,
    output logic              FINISHED
);

    localparam logic [2:0]        LAST_SEL  = 3'(NUM_MICS);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(DATA_W / 8);

    mic_dma_state_t state;
    logic           start_q;
    logic [31:0]    cnt;
`ifdef MIC_DMA_PENDING_FRAME_EN
    logic           pending;
`endif

    assign AM_BURSTCOUNT = BURST_ONE;
    assign AM_BYTEENABLE = BYTEEN_ALL;
    // select is held during a stall, so the external mux keeps data valid.
    assign AM_WRITEDATA  = mic_data;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            start_q  <= 1'b0;
            AM_ADDR  <= '0;
            select   <= '0;
            AM_WRITE <= 1'b0;
            FINISHED <= 1'b0;
            cnt      <= '0;
`ifdef MIC_DMA_PENDING_FRAME_EN
            pending  <= 1'b0;
`endif
        end else begin
            start_q <= start;
            case (state)
                IDLE: begin
                    if (start && !start_q) begin
                        AM_ADDR <= start_address;
                        cnt     <= number_samples;
                        if (number_samples == '0) begin
                            state    <= DONE;
                            FINISHED <= 1'b1;
                        end else begin
                            state <= WAIT_FRAME;
                        end
                    end
                end

                WAIT_FRAME: begin
                    if (!start) begin
                        state <= IDLE;
                    end else if (read_ready) begin
                        state    <= WRITE;
                        select   <= 3'd1;
                        AM_WRITE <= 1'b1;
                    end
                end

                WRITE: begin
`ifdef MIC_DMA_PENDING_FRAME_EN
                    if (read_ready) pending <= 1'b1;
`endif
                    // AM_WRITE is always 1 here; a beat retires when not stalled.
                    if (!AM_WAITREQUEST) begin
                        AM_ADDR <= AM_ADDR + ADDR_STEP;
                        if (!start) begin
                            // Aborted: the beat just retired, stop without FINISHED.
                            select   <= '0;
                            AM_WRITE <= 1'b0;
                            state    <= IDLE;
`ifdef MIC_DMA_PENDING_FRAME_EN
                            pending  <= 1'b0;
`endif
                        end else if (select != LAST_SEL) begin
                            select <= select + 3'd1;
                        end else begin
                            cnt <= cnt - 32'd1;
                            if (cnt == 32'd1) begin
                                select   <= '0;
                                AM_WRITE <= 1'b0;
                                state    <= DONE;
                                FINISHED <= 1'b1;
`ifdef MIC_DMA_PENDING_FRAME_EN
                                pending  <= 1'b0;
                            end else if (pending || read_ready) begin
                                // Frame already waiting: chain straight into it.
                                select  <= 3'd1;
                                pending <= 1'b0;
`endif
                            end else begin
                                select   <= '0;
                                AM_WRITE <= 1'b0;
                                state    <= WAIT_FRAME;
                            end
                        end
                    end
                end

                DONE: begin
                    if (!start) begin
                        state    <= IDLE;
                        FINISHED <= 1'b0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mic_dma_writer.sv
module tb_mic_dma_writer;

    localparam int NM = 4;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] AM_ADDR;
    logic [2:0]  AM_BURSTCOUNT;
    logic        AM_WRITE;
    logic [31:0] AM_WRITEDATA;
    logic [3:0]  AM_BYTEENABLE;
    logic        AM_WAITREQUEST;
    logic [31:0] mic_data;
    logic [2:0]  select;
    logic        start;
    logic        read_ready;
    logic [31:0] start_address;
    logic [31:0] number_samples;
    logic        FINISHED;

    logic [31:0] mic_word [8];
    logic [31:0] cap_addr [$];
    logic [2:0]  cap_sel  [$];
    logic [31:0] cap_data [$];

    int tests_run    = 0;
    int tests_failed = 0;
    int rand_wait    = 0;

    always #5 CLK = ~CLK;

    // External mic mux: the word depends only on select.
    assign mic_data = mic_word[select];

    mic_dma_writer #(.NUM_MICS(NM), .ADDR_W(32), .DATA_W(32)) dut (
        .CLK(CLK), .RESET(RESET),
        .AM_ADDR(AM_ADDR), .AM_BURSTCOUNT(AM_BURSTCOUNT), .AM_WRITE(AM_WRITE),
        .AM_WRITEDATA(AM_WRITEDATA), .AM_BYTEENABLE(AM_BYTEENABLE),
        .AM_WAITREQUEST(AM_WAITREQUEST), .mic_data(mic_data), .select(select),
        .start(start), .read_ready(read_ready), .start_address(start_address),
        .number_samples(number_samples), .FINISHED(FINISHED)
    );

    task automatic new_words();
        for (int i = 0; i < 8; i++) mic_word[i] = $urandom;
        cap_addr.delete(); cap_sel.delete(); cap_data.delete();
    endtask

    // Inputs are already set for the coming edge; record the beat it retires.
    task automatic step();
        if (rand_wait != 0) AM_WAITREQUEST = ($urandom_range(0, 2) == 0);
        if (AM_WRITE === 1'b1 && AM_WAITREQUEST === 1'b0) begin
            cap_addr.push_back(AM_ADDR);
            cap_sel.push_back(select);
            cap_data.push_back(AM_WRITEDATA);
        end
        @(posedge CLK); #1;
    endtask

    task automatic run_frame(output bit ok);
        read_ready = 1'b1; step(); read_ready = 1'b0;
        for (int c = 0; c < 200 && AM_WRITE === 1'b1; c++) step();
        AM_WAITREQUEST = 1'b0;
        ok = (AM_WRITE === 1'b0);
    endtask

    task automatic begin_transfer(input logic [31:0] base, input logic [31:0] n);
        start = 1'b0; step();
        start_address = base; number_samples = n; start = 1'b1; step();
    endtask

    task automatic do_transfer(input logic [31:0] base, input logic [31:0] n, output bit ok);
        bit fok;
        begin_transfer(base, n);
        ok = 1'b1;
        for (int f = 0; f < int'(n); f++) begin
            for (int g = 0, gn = $urandom_range(0, 2); g < gn; g++) step();
            run_frame(fok);
            ok &= fok;
        end
        AM_WAITREQUEST = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1; start = 1'b0; read_ready = 1'b0; AM_WAITREQUEST = 1'b0;
        start_address = '0; number_samples = '0;
        new_words();
        repeat (2) @(posedge CLK);
        #1;
        tests_run++;
        if (AM_WRITE !== 1'b0 || AM_ADDR !== 32'h0 || select !== 3'd0 || FINISHED !== 1'b0 ||
            AM_BURSTCOUNT !== 3'd1 || AM_BYTEENABLE !== 4'hF) begin
            tests_failed++;
            $display("FAIL reset_state: wr=%b addr=%h sel=%0d fin=%b bc=%0d be=%h, expected 0 0 0 0 1 f",
                     AM_WRITE, AM_ADDR, select, FINISHED, AM_BURSTCOUNT, AM_BYTEENABLE);
        end
        RESET = 1'b0;
        step();
    endtask

    task automatic test_basic();
        bit ok;
        new_words();
        begin_transfer(32'h1000, 2);
        read_ready = 1'b1; step(); read_ready = 1'b0;
        tests_run++;
        if (AM_WRITE !== 1'b1 || select !== 3'd1 || AM_ADDR !== 32'h1000) begin
            tests_failed++;
            $display("FAIL basic_latency: wr=%b sel=%0d addr=%h, expected 1 1 00001000", AM_WRITE, select, AM_ADDR);
        end
        for (int c = 0; c < 50 && AM_WRITE === 1'b1; c++) step();
        run_frame(ok);
        tests_run++;
        if (!ok || FINISHED !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_finished: ok=%b fin=%b, expected 1 1", ok, FINISHED);
        end
        tests_run++;
        if (cap_addr.size() != 2 * NM) begin
            tests_failed++;
            $display("FAIL basic_count: beats=%0d, expected %0d", cap_addr.size(), 2 * NM);
        end
        for (int k = 0; k < cap_addr.size() && k < 2 * NM; k++) begin
            logic [31:0] ea; logic [2:0] es;
            ea = 32'h1000 + 32'(4 * k); es = 3'(k % NM + 1);
            tests_run++;
            if (cap_addr[k] !== ea || cap_sel[k] !== es || cap_data[k] !== mic_word[es]) begin
                tests_failed++;
                $display("FAIL basic_beat%0d: addr=%h sel=%0d data=%h, expected %h %0d %h",
                         k, cap_addr[k], cap_sel[k], cap_data[k], ea, es, mic_word[es]);
            end
        end
        // start held high: no retrigger, FINISHED stays.
        for (int c = 0; c < 3; c++) begin
            read_ready = (c == 1); step();
        end
        read_ready = 1'b0;
        tests_run++;
        if (FINISHED !== 1'b1 || cap_addr.size() != 2 * NM || AM_WRITE !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_hold: fin=%b beats=%0d wr=%b, expected 1 %0d 0", FINISHED, cap_addr.size(), AM_WRITE, 2 * NM);
        end
        start = 1'b0; step();
        tests_run++;
        if (FINISHED !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_fin_clear: fin=%b, expected 0", FINISHED);
        end
    endtask

    task automatic test_stall();
        bit ok;
        new_words();
        begin_transfer(32'h1000, 1);
        read_ready = 1'b1; step(); read_ready = 1'b0;
        step(); // beat 1 retires
        AM_WAITREQUEST = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            tests_run++;
            if (AM_ADDR !== 32'h1004 || select !== 3'd2 || AM_WRITE !== 1'b1) begin
                tests_failed++;
                $display("FAIL stall_hold%0d: addr=%h sel=%0d wr=%b, expected 00001004 2 1", c, AM_ADDR, select, AM_WRITE);
            end
        end
        AM_WAITREQUEST = 1'b0;
        for (int c = 0; c < 50 && AM_WRITE === 1'b1; c++) step();
        ok = (AM_WRITE === 1'b0);
        tests_run++;
        if (!ok || cap_addr.size() != NM || FINISHED !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_count: beats=%0d fin=%b, expected %0d 1", cap_addr.size(), FINISHED, NM);
        end
        for (int k = 0; k < cap_addr.size() && k < NM; k++) begin
            tests_run++;
            if (cap_addr[k] !== 32'h1000 + 32'(4 * k) || cap_sel[k] !== 3'(k + 1)) begin
                tests_failed++;
                $display("FAIL stall_beat%0d: addr=%h sel=%0d, expected %h %0d", k, cap_addr[k], cap_sel[k],
                         32'h1000 + 32'(4 * k), k + 1);
            end
        end
        start = 1'b0; step();
    endtask

    task automatic test_zero_count();
        new_words();
        begin_transfer(32'h5000, 0);
        for (int c = 0; c < 3; c++) begin
            read_ready = (c == 1); step();
        end
        read_ready = 1'b0;
        tests_run++;
        if (FINISHED !== 1'b1 || AM_WRITE !== 1'b0 || cap_addr.size() != 0) begin
            tests_failed++;
            $display("FAIL zero_count: fin=%b wr=%b beats=%0d, expected 1 0 0", FINISHED, AM_WRITE, cap_addr.size());
        end
        start = 1'b0; step();
    endtask

    task automatic test_abort();
        bit ok;
        new_words();
        begin_transfer(32'h3000, 2);
        read_ready = 1'b1; step(); read_ready = 1'b0;
        step();
        AM_WAITREQUEST = 1'b1; step(); step();
        start = 1'b0; step();
        tests_run++;
        if (AM_WRITE !== 1'b1 || select !== 3'd2 || AM_ADDR !== 32'h3004) begin
            tests_failed++;
            $display("FAIL abort_inflight: wr=%b sel=%0d addr=%h, expected 1 2 00003004", AM_WRITE, select, AM_ADDR);
        end
        AM_WAITREQUEST = 1'b0; step();
        step(); step();
        tests_run++;
        if (AM_WRITE !== 1'b0 || select !== 3'd0 || FINISHED !== 1'b0 || cap_addr.size() != 2) begin
            tests_failed++;
            $display("FAIL abort_idle: wr=%b sel=%0d fin=%b beats=%0d, expected 0 0 0 2",
                     AM_WRITE, select, FINISHED, cap_addr.size());
        end
        cap_addr.delete(); cap_sel.delete(); cap_data.delete();
        do_transfer(32'h2000, 1, ok);
        tests_run++;
        if (!ok || FINISHED !== 1'b1 || cap_addr.size() != NM || cap_addr[0] !== 32'h2000 ||
            cap_addr[NM-1] !== 32'h2000 + 32'(4 * (NM - 1))) begin
            tests_failed++;
            $display("FAIL abort_restart: ok=%b fin=%b beats=%0d first=%h, expected 1 1 %0d 00002000",
                     ok, FINISHED, cap_addr.size(), (cap_addr.size() > 0) ? cap_addr[0] : 32'hx, NM);
        end
        start = 1'b0; step();
    endtask

    task automatic test_reset_midframe();
        new_words();
        begin_transfer(32'h6000, 2);
        read_ready = 1'b1; step(); read_ready = 1'b0;
        #2 RESET = 1'b1; start = 1'b0;
        #1;
        tests_run++;
        if (AM_WRITE !== 1'b0 || select !== 3'd0 || FINISHED !== 1'b0 || AM_ADDR !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_mid: wr=%b sel=%0d fin=%b addr=%h, expected 0 0 0 0", AM_WRITE, select, FINISHED, AM_ADDR);
        end
        @(posedge CLK); #1 RESET = 1'b0;
        begin_transfer(32'h6000, 0);
        #2 RESET = 1'b1; start = 1'b0;
        #1;
        tests_run++;
        if (FINISHED !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_done: fin=%b, expected 0", FINISHED);
        end
        @(posedge CLK); #1 RESET = 1'b0;
        step();
    endtask

    task automatic test_overlap();
        bit ok;
        new_words();
        begin_transfer(32'h4000, 3);
        read_ready = 1'b1; step(); read_ready = 1'b0;
        for (int c = 0; c < 50 && cap_addr.size() < NM; c++) begin
            read_ready = (select == 3'd1 || select == 3'd3); step();
        end
        read_ready = 1'b0;
`ifdef MIC_DMA_PENDING_FRAME_EN
        tests_run++;
        if (AM_WRITE !== 1'b1 || select !== 3'd1) begin
            tests_failed++;
            $display("FAIL overlap_chain: wr=%b sel=%0d, expected 1 1", AM_WRITE, select);
        end
        for (int c = 0; c < 50 && cap_addr.size() < 2 * NM; c++) step();
        step(); step();
        tests_run++;
        if (AM_WRITE !== 1'b0 || cap_addr.size() != 2 * NM) begin
            tests_failed++;
            $display("FAIL overlap_second_drop: wr=%b beats=%0d, expected 0 %0d", AM_WRITE, cap_addr.size(), 2 * NM);
        end
        run_frame(ok);
`else
        step(); step();
        tests_run++;
        if (AM_WRITE !== 1'b0 || select !== 3'd0 || cap_addr.size() != NM) begin
            tests_failed++;
            $display("FAIL overlap_drop: wr=%b sel=%0d beats=%0d, expected 0 0 %0d", AM_WRITE, select, cap_addr.size(), NM);
        end
        run_frame(ok);
        run_frame(ok);
`endif
        tests_run++;
        if (!ok || FINISHED !== 1'b1 || cap_addr.size() != 3 * NM) begin
            tests_failed++;
            $display("FAIL overlap_total: ok=%b fin=%b beats=%0d, expected 1 1 %0d", ok, FINISHED, cap_addr.size(), 3 * NM);
        end
        for (int k = 0; k < cap_addr.size() && k < 3 * NM; k++) begin
            tests_run++;
            if (cap_addr[k] !== 32'h4000 + 32'(4 * k) || cap_sel[k] !== 3'(k % NM + 1)) begin
                tests_failed++;
                $display("FAIL overlap_beat%0d: addr=%h sel=%0d, expected %h %0d", k, cap_addr[k], cap_sel[k],
                         32'h4000 + 32'(4 * k), k % NM + 1);
            end
        end
        start = 1'b0; step();
    endtask

    task automatic test_random();
        bit ok;
        for (int t = 0; t < 6; t++) begin
            logic [31:0] base, n;
            new_words();
            base = (t % 3 == 0) ? 32'hFFFF_FFF0 : {$urandom, 2'b00};
            n = 32'($urandom_range(1, 3));
            rand_wait = 1;
            do_transfer(base, n, ok);
            rand_wait = 0;
            AM_WAITREQUEST = 1'b0;
            tests_run++;
            if (!ok || FINISHED !== 1'b1 || cap_addr.size() != NM * int'(n)) begin
                tests_failed++;
                $display("FAIL rand%0d_count: ok=%b fin=%b beats=%0d, expected 1 1 %0d",
                         t, ok, FINISHED, cap_addr.size(), NM * int'(n));
            end
            for (int k = 0; k < cap_addr.size() && k < NM * int'(n); k++) begin
                logic [31:0] ea; logic [2:0] es;
                ea = base + 32'(4 * k); es = 3'(k % NM + 1);
                tests_run++;
                if (cap_addr[k] !== ea || cap_sel[k] !== es || cap_data[k] !== mic_word[es]) begin
                    tests_failed++;
                    $display("FAIL rand%0d_beat%0d: addr=%h sel=%0d data=%h, expected %h %0d %h",
                             t, k, cap_addr[k], cap_sel[k], cap_data[k], ea, es, mic_word[es]);
                end
            end
            start = 1'b0; step();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_zero_count();
        test_abort();
        test_reset_midframe();
        test_overlap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
